vram_arbiter: RTL and testbench

//  Shares one single-port synchronous video RAM between VGA scanout reads and

---
 rtl/vram_arbiter.sv | 111 +++++++++++
 tb/tb_vram_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Arbitrates one single-port synchronous tile RAM between VGA scanout reads
// (priority, on pixel strobes) and game-logic writes through a req/ack handshake.
`timescale 1ns/1ps
module vram_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              clr_err,
  output logic              err_starve,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, RD, WR, ACK_GAP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              wr_grant_q, wr_grant_d;
  logic              rd_data_q, rd_data_d;
  logic              disp_valid_q, disp_valid_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              err_q, err_d;
  logic              grant_rd, grant_wr;

  always_comb begin
    grant_rd = clk_en & disp_req;
    // A write is never granted in the cycle its ack is showing (state WR)
    grant_wr = !grant_rd && wr_req && (state_q != WR);

    if (grant_rd)            state_d = RD;
    else if (grant_wr)       state_d = WR;
    else if (state_q == WR)  state_d = ACK_GAP;
    else                     state_d = IDLE;

    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (grant_rd) begin
      ram_addr_d = disp_addr;
    end else if (grant_wr) begin
      ram_addr_d  = wr_addr;
      ram_wdata_d = wr_data;
    end
    wr_grant_d = grant_wr;

    // rd_data_q marks the cycle in which ram_rdata carries the scanout word
    rd_data_d    = (state_q == RD);
    disp_valid_d = rd_data_q;
    disp_data_d  = rd_data_q ? ram_rdata : disp_data_q;

    starve_cnt_d = '0;
    if (wr_req && !grant_wr) begin
      starve_cnt_d = (starve_cnt_q == CNT_MAX) ? CNT_MAX : starve_cnt_q + CNT_W'(1);
    end

    if (starve_cnt_d == CNT_MAX) err_d = 1'b1;
    else if (clr_err)            err_d = 1'b0;
    else                         err_d = err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      wr_grant_q   <= 1'b0;
      rd_data_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      starve_cnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      wr_grant_q   <= wr_grant_d;
      rd_data_q    <= rd_data_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      starve_cnt_q <= starve_cnt_d;
      err_q        <= err_d;
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_we     = wr_grant_q;
  assign wr_ack     = wr_grant_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;
  assign err_starve = err_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: bench-side RAM, a queue/array reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_vram_arbiter;

  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 4;
  localparam int STARVE_MAX = 8;
  localparam int DEPTH      = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clk_en = 1'b0, disp_req = 1'b0, wr_req = 1'b0, clr_err = 1'b0;
  logic [ADDR_W-1:0] disp_addr = '0, wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [DATA_W-1:0] disp_data, ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic              disp_valid, wr_ack, err_starve, ram_we;
  logic [ADDR_W-1:0] ram_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .disp_req(disp_req),
    .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .clr_err(clr_err), .err_starve(err_starve), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Single-port synchronous RAM, read-before-write, one cycle read latency
  logic [DATA_W-1:0] mem [DEPTH];
  int ram_writes = 0;
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      ram_writes    <= ram_writes + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a read returns the memory image at grant time after a
  // fixed delay; writes land one edge after their grant unless reset intervenes.
  typedef struct { int due; logic [DATA_W-1:0] data; } rd_t;
  rd_t               rdq[$];
  logic [DATA_W-1:0] shadow [DEPTH];
  int                m_cyc = 0;
  int                m_cnt = 0;
  bit                m_ack = 0, m_valid = 0, m_err = 0, pend = 0, g_rd, g_wr;
  logic [DATA_W-1:0] m_data = '0, m_wdata = '0, pend_data = '0;
  logic [ADDR_W-1:0] m_addr = '0, pend_addr = '0;
  rd_t               entry;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ack = 0; m_valid = 0; m_err = 0; m_cnt = 0; pend = 0;
      m_data = '0; m_wdata = '0; m_addr = '0;
      rdq.delete();
    end else begin
      m_cyc++;
      if (pend) shadow[pend_addr] = pend_data;
      pend    = 0;
      m_valid = 0;
      if (rdq.size() > 0 && rdq[0].due == m_cyc) begin
        m_valid = 1;
        m_data  = rdq[0].data;
        void'(rdq.pop_front());
      end
      g_rd = clk_en && disp_req;
      g_wr = !g_rd && wr_req && !m_ack;
      if (g_rd) begin
        entry.due  = m_cyc + 2;
        entry.data = shadow[disp_addr];
        rdq.push_back(entry);
        m_addr = disp_addr;
      end
      if (g_wr) begin
        pend = 1; pend_addr = wr_addr; pend_data = wr_data;
        m_addr = wr_addr; m_wdata = wr_data;
      end
      m_ack = g_wr;
      if (wr_req && !g_wr) m_cnt = (m_cnt < STARVE_MAX) ? m_cnt + 1 : STARVE_MAX;
      else                 m_cnt = 0;
      if (m_cnt == STARVE_MAX) m_err = 1;
      else if (clr_err)        m_err = 0;
    end
  end

  always @(negedge clk) begin
    checkOutput("disp_valid", disp_valid, m_valid);
    checkOutput("disp_data",  disp_data,  m_data);
    checkOutput("wr_ack",     wr_ack,     m_ack);
    checkOutput("ram_we",     ram_we,     m_ack);
    checkOutput("ram_addr",   ram_addr,   m_addr);
    checkOutput("ram_wdata",  ram_wdata,  m_wdata);
    checkOutput("err_starve", err_starve, m_err);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input bit ce, input bit dr, input logic [ADDR_W-1:0] da,
                               input bit wr, input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd, input bit clr);
    clk_en = ce; disp_req = dr; disp_addr = da;
    wr_req = wr; wr_addr = wa; wr_data = wd; clr_err = clr;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] v;
    int acks, cyc, back2back, w0, mism;
    bit prev;

    for (int i = 0; i < DEPTH; i++) begin
      v = DATA_W'($urandom);
      mem[i] = v;
      shadow[i] = v;
    end
    mem[11'h012] = 4'hA; shadow[11'h012] = 4'hA;
    mem[11'h123] = 4'h0; shadow[11'h123] = 4'h0;
    mem[11'h500] = 4'h0; shadow[11'h500] = 4'h0;

    // Reset state
    tick(3);
    checkOutput("rst_disp_valid", disp_valid, 0);
    checkOutput("rst_wr_ack",     wr_ack,     0);
    checkOutput("rst_ram_we",     ram_we,     0);
    checkOutput("rst_err",        err_starve, 0);
    checkOutput("rst_ram_addr",   ram_addr,   0);
    checkOutput("rst_disp_data",  disp_data,  0);
    reset = 1'b0;
    tick(2);

    // Scanout reads on a 1-in-4 strobe
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 11'h012, 0, '0, '0, 0);
      tick(1);
      applyStimulus(0, 1, 11'h012, 0, '0, '0, 0);
      checkOutput("t1_addr", ram_addr, 11'h012);
      checkOutput("t1_early1", disp_valid, 0);
      tick(1);
      checkOutput("t1_early2", disp_valid, 0);
      tick(1);
      checkOutput("t1_valid", disp_valid, 1);
      checkOutput("t1_data", disp_data, 4'hA);
      tick(1);
      checkOutput("t1_pulse_end", disp_valid, 0);
      checkOutput("t1_data_hold", disp_data, 4'hA);
    end

    // Single write in a non-strobe cycle, then read it back
    applyStimulus(0, 0, '0, 1, 11'h123, 4'h5, 0);
    tick(1);
    checkOutput("t2_we", ram_we, 1);
    checkOutput("t2_ack", wr_ack, 1);
    checkOutput("t2_addr", ram_addr, 11'h123);
    checkOutput("t2_wdata", ram_wdata, 4'h5);
    applyStimulus(0, 0, '0, 0, 11'h123, 4'h5, 0);
    tick(1);
    checkOutput("t2_ack_drop", wr_ack, 0);
    checkOutput("t2_addr_hold", ram_addr, 11'h123);
    applyStimulus(1, 1, 11'h123, 0, '0, '0, 0);
    tick(1);
    applyStimulus(0, 0, 11'h123, 0, '0, '0, 0);
    tick(2);
    checkOutput("t2_rd_valid", disp_valid, 1);
    checkOutput("t2_rd_data", disp_data, 4'h5);
    tick(1);

    // Write request collides with a strobe: read goes first
    applyStimulus(1, 1, 11'h012, 1, 11'h200, 4'h7, 0);
    tick(1);
    checkOutput("t3_no_ack", wr_ack, 0);
    checkOutput("t3_rd_addr", ram_addr, 11'h012);
    applyStimulus(0, 0, 11'h012, 1, 11'h200, 4'h7, 0);
    tick(1);
    checkOutput("t3_ack", wr_ack, 1);
    checkOutput("t3_wr_addr", ram_addr, 11'h200);
    applyStimulus(0, 0, '0, 0, '0, '0, 0);
    tick(2);

    // Back-to-back write stream
    w0 = ram_writes;
    applyStimulus(0, 0, '0, 1, 11'h300, 4'h0, 0);
    acks = 0; cyc = 0; back2back = 0; prev = 0;
    while (acks < 6 && cyc < 20) begin
      tick(1);
      cyc++;
      if (wr_ack && prev) back2back++;
      prev = wr_ack;
      if (wr_ack) begin
        acks++;
        if (acks < 6) begin
          wr_addr = 11'h300 + 11'(acks);
          wr_data = acks[3:0];
        end else begin
          wr_req = 1'b0;
        end
      end
    end
    tick(1);
    checkOutput("t4_acks", acks, 6);
    checkOutput("t4_cycles", cyc, 11);
    checkOutput("t4_back2back", back2back, 0);
    checkOutput("t4_ram_writes", ram_writes - w0, 6);
    mism = 0;
    for (int i = 0; i < 6; i++) if (mem[11'h300 + 11'(i)] !== DATA_W'(i)) mism++;
    checkOutput("t4_ram_contents", mism, 0);

    // Starvation under a permanently busy scanout
    applyStimulus(1, 1, 11'h012, 1, 11'h400, 4'h9, 0);
    for (int i = 1; i <= STARVE_MAX; i++) begin
      tick(1);
      if (i < STARVE_MAX) checkOutput("t5_not_yet", err_starve, 0);
      else                checkOutput("t5_set", err_starve, 1);
    end
    tick(3);
    checkOutput("t5_sticky", err_starve, 1);
    clr_err = 1'b1;
    tick(1);
    checkOutput("t5_set_wins", err_starve, 1);
    applyStimulus(0, 0, '0, 0, '0, '0, 1);
    tick(1);
    checkOutput("t5_cleared", err_starve, 0);
    clr_err = 1'b0;
    tick(3);

    // Reset one cycle after a read is issued, with a write in flight
    applyStimulus(1, 1, 11'h012, 1, 11'h500, 4'hB, 0);
    tick(1);
    applyStimulus(0, 0, 11'h012, 1, 11'h500, 4'hB, 0);
    tick(1);
    checkOutput("t6_pre_we", ram_we, 1);
    reset = 1'b1;
    #1;
    checkOutput("t6_valid0", disp_valid, 0);
    checkOutput("t6_we0", ram_we, 0);
    checkOutput("t6_ack0", wr_ack, 0);
    applyStimulus(0, 0, '0, 0, '0, '0, 0);
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput("t6_no_late_valid", disp_valid, 0);
    end
    checkOutput("t6_write_dropped", mem[11'h500], 4'h0);

    // Random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      if (wr_req && wr_ack) begin
        wr_req = 1'($urandom_range(0, 1));
        wr_addr = 11'h010 + 11'($urandom_range(0, 7));
        wr_data = DATA_W'($urandom);
      end else if (!wr_req && $urandom_range(0, 2) == 0) begin
        wr_req = 1'b1;
        wr_addr = 11'h010 + 11'($urandom_range(0, 7));
        wr_data = DATA_W'($urandom);
      end
      if (c >= 500 && c < 560) clk_en = 1'b1;
      else if (c < 1000)       clk_en = (c % 4 == 0);
      else                     clk_en = ($urandom_range(0, 2) == 0);
      disp_req  = ($urandom_range(0, 3) != 0);
      disp_addr = 11'h010 + 11'($urandom_range(0, 7));
      clr_err   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        wr_req = 1'b0;
      end
      tick(1);
    end

    applyStimulus(0, 0, '0, 0, '0, '0, 0);
    tick(4);
    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== shadow[i]) mism++;
    checkOutput("ram_image", mism, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
